// File: rtl/lc3_io_pkg.sv
// rtl/lc3_io_pkg.sv - shared types and constants for the LC3 console output path
package lc3_io_pkg;

   localparam int CHAR_W = 8;

   localparam logic UART_START_BIT = 1'b0;
   localparam logic UART_STOP_BIT  = 1'b1;

   localparam logic [CHAR_W-1:0] ASCII_CR = 8'h0D;
   localparam logic [CHAR_W-1:0] ASCII_LF = 8'h0A;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } tx_state_t;

endpackage

// File: rtl/lc3_sync_fifo.sv
// rtl/lc3_sync_fifo.sv - single-clock character FIFO with occupancy count
// A push into a full FIFO is accepted only when a pop retires the head on the same edge.
module lc3_sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8,
   parameter int AW    = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic [AW:0]      level,
   output logic             full,
   output logic             empty
);

   localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             push_ok;
   logic             pop_ok;

   assign full    = (level == FULL_LVL);
   assign empty   = (level == '0);
   assign pop_ok  = pop & ~empty;
   assign push_ok = push & (~full | pop_ok);
   assign dout    = mem[rd_ptr];

   // Storage carries no reset; contents are discarded by clearing the pointers.
   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem[wr_ptr] <= din;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (push_ok) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop_ok) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({push_ok, pop_ok})
            2'b10:   level <= level + (AW+1)'(1);
            2'b01:   level <= level - (AW+1)'(1);
            default: level <= level;
         endcase
      end
   end

endmodule

// File: rtl/lc3_ddr_uart_tx.sv
// rtl/lc3_ddr_uart_tx.sv - LC3 display register capture FIFO draining as 8N1 UART frames
// Optional CRLF_EXPAND_EN: a popped LF is sent as CR followed by LF.
module lc3_ddr_uart_tx
   import lc3_io_pkg::*;
#(
   parameter int CLKS_PER_BIT = 16,
   parameter int FIFO_DEPTH   = 8,
   parameter int FIFO_AW      = 3
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               WR_DDR,
   input  logic [15:0]        DDR,
   output logic               tx,
   output logic               ddr_ready,
   output logic               busy,
   output logic               empty,
   output logic               full,
   output logic               overflow,
   output logic [FIFO_AW:0]   level
);

   localparam int          CW       = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] LAST_CLK = CW'(CLKS_PER_BIT - 1);

   tx_state_t         state;
   logic [CW-1:0]     clk_cnt;
   logic [2:0]        bit_idx;
   logic [CHAR_W-1:0] shift;
   logic [CHAR_W-1:0] fifo_dout;
   logic [CHAR_W-1:0] frame_char;
   logic              bit_end;
   logic              fifo_pop;
   logic              start_frame;
   logic              lf_hold;
   logic              unused_ddr_hi;

   assign unused_ddr_hi = ^DDR[15:8];

   lc3_sync_fifo #(
      .WIDTH (CHAR_W),
      .DEPTH (FIFO_DEPTH),
      .AW    (FIFO_AW)
   ) u_fifo (
      .clk   (clk),
      .rst_n (reset),
      .push  (WR_DDR),
      .din   (DDR[CHAR_W-1:0]),
      .pop   (fifo_pop),
      .dout  (fifo_dout),
      .level (level),
      .full  (full),
      .empty (empty)
   );

`ifdef CRLF_EXPAND_EN
   logic lf_pending;
   assign lf_hold = lf_pending;
`else
   assign lf_hold = 1'b0;
`endif

   assign ddr_ready   = ~full;
   assign bit_end     = (clk_cnt == LAST_CLK);
   assign fifo_pop    = ~empty & ~lf_hold & ((state == IDLE) | ((state == STOP) & bit_end));
   assign start_frame = fifo_pop | (lf_hold & (state == STOP) & bit_end);

   always_comb begin
      frame_char = fifo_dout;
`ifdef CRLF_EXPAND_EN
      if (lf_pending) begin
         frame_char = ASCII_LF;
      end else if (fifo_dout == ASCII_LF) begin
         frame_char = ASCII_CR;
      end
`endif
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= IDLE;
         tx      <= UART_STOP_BIT;
         busy    <= 1'b0;
         clk_cnt <= '0;
         bit_idx <= '0;
         shift   <= '0;
`ifdef CRLF_EXPAND_EN
         lf_pending <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               tx   <= UART_STOP_BIT;
               busy <= 1'b0;
            end
            START: begin
               if (bit_end) begin
                  clk_cnt <= '0;
                  bit_idx <= '0;
                  tx      <= shift[0];
                  state   <= DATA;
               end else begin
                  clk_cnt <= clk_cnt + CW'(1);
               end
            end
            DATA: begin
               if (bit_end) begin
                  clk_cnt <= '0;
                  if (bit_idx == 3'd7) begin
                     tx    <= UART_STOP_BIT;
                     state <= STOP;
                  end else begin
                     bit_idx <= bit_idx + 3'd1;
                     shift   <= shift >> 1;
                     tx      <= shift[1];
                  end
               end else begin
                  clk_cnt <= clk_cnt + CW'(1);
               end
            end
            STOP: begin
               if (bit_end) begin
                  clk_cnt <= '0;
                  tx      <= UART_STOP_BIT;
                  busy    <= 1'b0;
                  state   <= IDLE;
               end else begin
                  clk_cnt <= clk_cnt + CW'(1);
               end
            end
            default: begin
               tx    <= UART_STOP_BIT;
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase

         // Loading the next frame overrides the end-of-stop return to IDLE, giving gapless frames.
         if (start_frame) begin
            shift   <= frame_char;
            clk_cnt <= '0;
            tx      <= UART_START_BIT;
            busy    <= 1'b1;
            state   <= START;
`ifdef CRLF_EXPAND_EN
            lf_pending <= fifo_pop & (fifo_dout == ASCII_LF);
`endif
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         overflow <= 1'b0;
      end else if (WR_DDR & full & ~fifo_pop) begin
         overflow <= 1'b1;
      end
   end

endmodule

// File: tb/tb_lc3_ddr_uart_tx.sv
// tb/tb_lc3_ddr_uart_tx.sv - self-checking bench for lc3_ddr_uart_tx
module tb_lc3_ddr_uart_tx;

   localparam int C = 16;

   logic        clk;
   logic        reset;
   logic        WR_DDR;
   logic [15:0] DDR;
   logic        tx;
   logic        ddr_ready;
   logic        busy;
   logic        empty;
   logic        full;
   logic        overflow;
   logic [3:0]  level;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   lc3_ddr_uart_tx #(
      .CLKS_PER_BIT (C),
      .FIFO_DEPTH   (8),
      .FIFO_AW      (3)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .WR_DDR    (WR_DDR),
      .DDR       (DDR),
      .tx        (tx),
      .ddr_ready (ddr_ready),
      .busy      (busy),
      .empty     (empty),
      .full      (full),
      .overflow  (overflow),
      .level     (level)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Serial receiver: samples tx mid-bit on falling clock edges and queues each decoded byte.
   logic [7:0] rx_q[$];
   logic       rx_act = 1'b0;
   int         rx_cnt = 0;
   logic [7:0] rx_sh  = 8'h00;

   always @(negedge clk) begin
      if (!reset) begin
         rx_act <= 1'b0;
      end else if (!rx_act) begin
         if (tx == 1'b0) begin
            rx_act <= 1'b1;
            rx_cnt <= 0;
         end
      end else begin
         rx_cnt <= rx_cnt + 1;
         if (rx_cnt == C/2) begin
            chk("rx_start_bit", {31'd0, tx}, 32'd0);
         end
         if (rx_cnt >= C/2 + C && rx_cnt <= C/2 + 8*C && ((rx_cnt - C/2) % C) == 0) begin
            rx_sh <= {tx, rx_sh[7:1]};
         end
         if (rx_cnt == C/2 + 9*C) begin
            chk("rx_stop_bit", {31'd0, tx}, 32'd1);
            rx_q.push_back(rx_sh);
            rx_act <= 1'b0;
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [15:0] d);
      WR_DDR = 1'b1;
      DDR    = d;
      step();
      WR_DDR = 1'b0;
      DDR    = 16'h0000;
   endtask

   task automatic wait_idle(input int budget);
      int n;
      n = 0;
      while (!(busy == 1'b0 && empty == 1'b1) && n < budget) begin
         step();
         n++;
      end
      chk("wait_idle_in_budget", {31'd0, (n < budget)}, 32'd1);
   endtask

   typedef struct {
      logic [15:0] ddr;
      int          n;
      logic [7:0]  e0;
      logic [7:0]  e1;
   } vec_t;

   vec_t vecs[6];

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int n0;
      int bc;
      int max_lvl;

      vecs[0] = '{16'hAB30, 1, 8'h30, 8'h00};
      vecs[1] = '{16'h00FF, 1, 8'hFF, 8'h00};
      vecs[2] = '{16'h0000, 1, 8'h00, 8'h00};
      vecs[3] = '{16'hFF55, 1, 8'h55, 8'h00};
      vecs[4] = '{16'h0080, 1, 8'h80, 8'h00};
`ifdef CRLF_EXPAND_EN
      vecs[5] = '{16'h000A, 2, 8'h0D, 8'h0A};
`else
      vecs[5] = '{16'h000A, 1, 8'h0A, 8'h00};
`endif

      reset  = 1'b0;
      WR_DDR = 1'b0;
      DDR    = 16'h0000;
      repeat (3) step();
      chk("rst_tx", {31'd0, tx}, 32'd1);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_ddr_ready", {31'd0, ddr_ready}, 32'd1);
      chk("rst_empty", {31'd0, empty}, 32'd1);
      chk("rst_full", {31'd0, full}, 32'd0);
      chk("rst_overflow", {31'd0, overflow}, 32'd0);
      chk("rst_level", {28'd0, level}, 32'd0);
      reset = 1'b1;
      step();

      // Single character: latency and frame length.
      rx_q.delete();
      wr(16'h0030);
      chk("lat_level_after_push", {28'd0, level}, 32'd1);
      chk("lat_tx_high_edge_n", {31'd0, tx}, 32'd1);
      step();
      chk("lat_tx_low_edge_n1", {31'd0, tx}, 32'd0);
      chk("lat_busy_edge_n1", {31'd0, busy}, 32'd1);
      bc = 1;
      while (busy && bc < 400) begin
         step();
         if (busy) bc++;
      end
      chk("single_busy_cycles", bc, 32'd160);
      chk("single_rx_count", rx_q.size(), 32'd1);
      if (rx_q.size() >= 1) chk("single_rx_byte", {24'd0, rx_q[0]}, 32'h30);

      // Table of single writes, including ignored high DDR bits.
      for (int i = 0; i < 6; i++) begin
         rx_q.delete();
         step();
         wr(vecs[i].ddr);
         wait_idle(2000);
         chk($sformatf("vec%0d_rx_count", i), rx_q.size(), vecs[i].n);
         if (rx_q.size() >= 1) chk($sformatf("vec%0d_rx0", i), {24'd0, rx_q[0]}, {24'd0, vecs[i].e0});
         if (rx_q.size() >= 2) chk($sformatf("vec%0d_rx1", i), {24'd0, rx_q[1]}, {24'd0, vecs[i].e1});
      end

      // Burst to full, push on the pop edge, then a dropped write.
      rx_q.delete();
      step();
      wr(16'h0041);
      n0 = cyc;
      for (int k = 1; k < 9; k++) wr(16'h0041 + 16'(k));
      chk("burst_full", {31'd0, full}, 32'd1);
      chk("burst_ddr_ready", {31'd0, ddr_ready}, 32'd0);
      chk("burst_level", {28'd0, level}, 32'd8);
      chk("burst_overflow_clear", {31'd0, overflow}, 32'd0);
      while (cyc < n0 + 160) step();
      wr(16'h004A);
      chk("simul_level", {28'd0, level}, 32'd8);
      chk("simul_overflow", {31'd0, overflow}, 32'd0);
      wr(16'h004B);
      chk("drop_overflow", {31'd0, overflow}, 32'd1);
      chk("drop_level", {28'd0, level}, 32'd8);
      wait_idle(4000);
      chk("burst_gapless_end", cyc - n0, 32'd1601);
      chk("burst_rx_count", rx_q.size(), 32'd10);
      for (int k = 0; k < 10; k++) begin
         if (rx_q.size() > k) chk($sformatf("burst_rx%0d", k), {24'd0, rx_q[k]}, 32'h41 + k);
      end
      chk("overflow_sticky", {31'd0, overflow}, 32'd1);

      // Paced stream across pointer wrap.
      rx_q.delete();
      max_lvl = 0;
      for (int k = 0; k < 20; k++) begin
         wr(16'h0060 + 16'(k));
         if (int'(level) > max_lvl) max_lvl = int'(level);
         repeat (160) begin
            step();
            if (int'(level) > max_lvl) max_lvl = int'(level);
         end
      end
      wait_idle(2000);
      chk("wrap_rx_count", rx_q.size(), 32'd20);
      for (int k = 0; k < 20; k++) begin
         if (rx_q.size() > k) chk($sformatf("wrap_rx%0d", k), {24'd0, rx_q[k]}, 32'h60 + k);
      end
      chk("wrap_level_le2", {31'd0, (max_lvl <= 2)}, 32'd1);

      // Reset in the middle of data bit 3 (0x52 has bit 3 low).
      rx_q.delete();
      step();
      wr(16'h0052);
      n0 = cyc;
      wr(16'h005B);
      while (cyc < n0 + 1 + 4*C + C/2) step();
      chk("mid_tx_bit3", {31'd0, tx}, 32'd0);
      chk("mid_busy", {31'd0, busy}, 32'd1);
      chk("mid_level", {28'd0, level}, 32'd1);
      reset = 1'b0;
      #1;
      chk("async_rst_tx", {31'd0, tx}, 32'd1);
      chk("async_rst_busy", {31'd0, busy}, 32'd0);
      chk("async_rst_level", {28'd0, level}, 32'd0);
      chk("async_rst_empty", {31'd0, empty}, 32'd1);
      chk("async_rst_overflow", {31'd0, overflow}, 32'd0);
      step();
      step();
      reset = 1'b1;
      step();
      rx_q.delete();
      wr(16'h0055);
      wait_idle(2000);
      chk("post_rst_rx_count", rx_q.size(), 32'd1);
      if (rx_q.size() >= 1) chk("post_rst_rx_byte", {24'd0, rx_q[0]}, 32'h55);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
